// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic scan controller: FSM encoding,
// echo-time to distance scaling and the distance saturation limit.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } scan_state_e;

    localparam int unsigned DIST_MUL    = 11;
    localparam int unsigned DIST_SHIFT  = 6;
    localparam int unsigned DIST_SAT_MM = 9999;
    localparam int unsigned US_CNT_W    = 20;

    // Round-trip echo time (us) to one-way distance (mm), ~0.1715 mm/us.
    function automatic logic [15:0] us_to_mm(input logic [US_CNT_W-1:0] echo_us);
        logic [23:0] prod;
        prod = (24'(echo_us) * 24'(DIST_MUL)) >> DIST_SHIFT;
        if (prod > 24'(DIST_SAT_MM)) begin
            return 16'(DIST_SAT_MM);
        end else begin
            return prod[15:0];
        end
    endfunction

endpackage

// File: rtl/us_echo_timer.sv
// Microsecond prescaler plus a us counter that flags when it reaches a limit.
// clr restarts both the prescaler and the count.
module us_echo_timer
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [US_CNT_W-1:0] limit,
    output logic [US_CNT_W-1:0] count_next,
    output logic                expire
);

    localparam int unsigned PRESC = (CLK_FREQ / 1_000_000 > 0) ? CLK_FREQ / 1_000_000 : 1;
    localparam int          PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0]       presc_q, presc_d;
    logic [US_CNT_W-1:0] count_q, count_d;
    logic                tick_s;

    // Tick generation and count; expire includes the tick of the current cycle.
    always_comb begin
        tick_s     = (presc_q == PW'(PRESC - 1));
        presc_d    = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
        count_next = (tick_s && (count_q < limit)) ? count_q + 20'd1 : count_q;
        expire     = tick_s && (count_next >= limit);
        if (clr) begin
            presc_d = {PW{1'b0}};
            count_d = {US_CNT_W{1'b0}};
        end else begin
            count_d = count_next;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= {PW{1'b0}};
            count_q <= {US_CNT_W{1'b0}};
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/us_scan_ctrl.sv
// Round-robin scanner for up to four ultrasonic rangers: trigger one sensor,
// time its echo, report distance or timeout, then hold off before the next.
module us_scan_ctrl
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_MS = 30,
    parameter int unsigned HOLDOFF_MS = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [3:0]  sensor_en,
    input  logic [3:0]  echo,
    output logic [3:0]  trig,
    output logic [15:0] dist_mm,
    output logic [1:0]  dist_id,
    output logic        dist_valid,
    output logic        timeout,
    output logic        busy
);

    localparam logic [US_CNT_W-1:0] TRIG_TICKS    = US_CNT_W'(TRIG_US);
    localparam logic [US_CNT_W-1:0] TIMEOUT_TICKS = US_CNT_W'(TIMEOUT_MS * 1000);
    localparam logic [US_CNT_W-1:0] HOLDOFF_TICKS = US_CNT_W'(HOLDOFF_MS * 1000);

    scan_state_e         state_q, state_d;
    logic [1:0]          sel_q, sel_d, last_q, last_d;
    logic                armed_q, armed_d;
    logic [3:0]          echo_meta_q, echo_sync_q;
    logic [3:0]          trig_q, trig_d;
    logic [15:0]         dist_mm_q, dist_mm_d;
    logic [1:0]          dist_id_q, dist_id_d;
    logic                dist_valid_q, dist_valid_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                echo_s, start_ok_s, clr_s, expire_s;
    logic [US_CNT_W-1:0] limit_s, count_next_s;

    // Nearest enabled sensor after 'last', wrapping; returns 'last' if it is the only one.
    function automatic logic [1:0] rr_next(input logic [1:0] last, input logic [3:0] mask);
        logic [1:0] idx;
        rr_next = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (mask[idx]) begin
                rr_next = idx;
            end else begin
                rr_next = rr_next;
            end
        end
    endfunction

    us_echo_timer #(.CLK_FREQ(CLK_FREQ)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr_s),
        .limit      (limit_s),
        .count_next (count_next_s),
        .expire     (expire_s)
    );

    assign echo_s     = echo_sync_q[sel_q];
    assign start_ok_s = enable && (sensor_en != 4'd0);

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        armed_d      = armed_q;
        dist_mm_d    = dist_mm_q;
        dist_id_d    = dist_id_q;
        dist_valid_d = 1'b0;
        timeout_d    = 1'b0;
        limit_s      = TIMEOUT_TICKS;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    sel_d   = rr_next(last_q, sensor_en);
                    last_d  = sel_d;
                    state_d = ST_TRIG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRIG: begin
                limit_s = TRIG_TICKS;
                armed_d = 1'b0;
                if (expire_s) begin
                    state_d = ST_WAIT_RISE;
                end else begin
                    state_d = ST_TRIG;
                end
            end
            // A rise only counts once the line has been seen low in this state.
            ST_WAIT_RISE: begin
                armed_d = armed_q | ~echo_s;
                if (armed_q && echo_s) begin
                    state_d = ST_MEASURE;
                end else if (expire_s) begin
                    timeout_d = 1'b1;
                    dist_id_d = sel_q;
                    state_d   = ST_HOLDOFF;
                end else begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_MEASURE: begin
                if (!echo_s) begin
                    dist_valid_d = 1'b1;
                    dist_mm_d    = us_to_mm(count_next_s);
                    dist_id_d    = sel_q;
                    state_d      = ST_HOLDOFF;
                end else if (expire_s) begin
                    timeout_d = 1'b1;
                    dist_id_d = sel_q;
                    state_d   = ST_HOLDOFF;
                end else begin
                    state_d = ST_MEASURE;
                end
            end
            ST_HOLDOFF: begin
                limit_s = HOLDOFF_TICKS;
                if (expire_s && start_ok_s) begin
                    sel_d   = rr_next(last_q, sensor_en);
                    last_d  = sel_d;
                    state_d = ST_TRIG;
                end else if (expire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLDOFF;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        clr_s  = (state_d != state_q);
        trig_d = (state_d == ST_TRIG) ? (4'b0001 << sel_d) : 4'b0000;
        busy_d = (state_d != ST_IDLE);
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= 2'd3;
            last_q       <= 2'd3;
            armed_q      <= 1'b0;
            echo_meta_q  <= 4'd0;
            echo_sync_q  <= 4'd0;
            trig_q       <= 4'd0;
            dist_mm_q    <= 16'd0;
            dist_id_q    <= 2'd0;
            dist_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            armed_q      <= armed_d;
            echo_meta_q  <= echo;
            echo_sync_q  <= echo_meta_q;
            trig_q       <= trig_d;
            dist_mm_q    <= dist_mm_d;
            dist_id_q    <= dist_id_d;
            dist_valid_q <= dist_valid_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign trig       = trig_q;
    assign dist_mm    = dist_mm_q;
    assign dist_id    = dist_id_q;
    assign dist_valid = dist_valid_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;

endmodule
